// File: rtl/genius_speed_ctrl_pkg.sv
// Shared types for the Genius tempo path: game FSM states and the level type.
package genius_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OVER = 2'd2
   } state_e;

   typedef logic [1:0] level_t;

   localparam level_t LVL_MAX = 2'd3;

endpackage

// File: rtl/genius_speed_ctrl_if.sv
// Event and tempo bus between the game controller, the speed scheduler and the LED timing logic.
interface genius_speed_ctrl_if;
   logic       start_i;
   logic       round_ok_i;
   logic       game_over_i;
   logic [3:0] tick_o;
   logic [1:0] level_o;
   logic       sel_tick_o;
   logic       pend_o;
   logic       max_o;
   logic [1:0] state_o;

   modport slave (
      input  start_i, round_ok_i, game_over_i,
      output tick_o, level_o, sel_tick_o, pend_o, max_o, state_o
   );

   modport master (
      output start_i, round_ok_i, game_over_i,
      input  tick_o, level_o, sel_tick_o, pend_o, max_o, state_o
   );
endinterface

// File: rtl/genius_speed_ctrl_clk_div_tick.sv
// Free-running divide-by-DIV tick enable; the tick is decoded from the counter register only.
module clk_div_tick #(
   parameter int DIV = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   output logic tick_o
);
   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + W'(1);
      if (clr_i || cnt_q == LAST) cnt_d = '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tick_o = (cnt_q == LAST);
endmodule

// File: rtl/genius_speed_ctrl.sv
// Genius tempo scheduler: four level ticks, game FSM, round counter and tick-aligned level application.
module genius_speed_ctrl
   import genius_pkg::*;
#(
   parameter int DIV0             = 50_000_000,
   parameter int DIV1             = 37_500_000,
   parameter int DIV2             = 25_000_000,
   parameter int DIV3             = 12_500_000,
   parameter int ROUNDS_PER_LEVEL = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   genius_speed_ctrl_if.slave    bus
);
   localparam int RW = (ROUNDS_PER_LEVEL > 1) ? $clog2(ROUNDS_PER_LEVEL) : 1;
   localparam logic [RW-1:0] RND_LAST = RW'(ROUNDS_PER_LEVEL - 1);

   state_e        state_q, state_d;
   level_t        level_q, level_d;
   level_t        pend_q, pend_d;
   logic [RW-1:0] rnd_q, rnd_d;
   logic [3:0]    tick;
   logic          apply, clr;

   // All dividers restart together so the first period after a change is full length.
   for (genvar k = 0; k < 4; k++) begin : g_div
      localparam int D = (k == 0) ? DIV0 : (k == 1) ? DIV1 : (k == 2) ? DIV2 : DIV3;
      clk_div_tick #(.DIV(D)) u_div (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .clr_i (clr),
         .tick_o(tick[k])
      );
   end

   assign apply = (state_q == ST_RUN) && tick[level_q] && (pend_q != level_q);
   assign clr   = bus.start_i || apply;

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      pend_d  = pend_q;
      rnd_d   = rnd_q;
      if (apply) level_d = pend_q;
      if (bus.start_i) begin
         state_d = ST_RUN;
         level_d = '0;
         pend_d  = '0;
         rnd_d   = '0;
      end else if (state_q == ST_RUN) begin
         if (bus.game_over_i) begin
            state_d = ST_OVER;
         end else if (bus.round_ok_i) begin
            if (rnd_q == RND_LAST) begin
               rnd_d = '0;
               if (pend_q != LVL_MAX) pend_d = pend_q + 2'd1;
            end else begin
               rnd_d = rnd_q + RW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         level_q <= '0;
         pend_q  <= '0;
         rnd_q   <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         pend_q  <= pend_d;
         rnd_q   <= rnd_d;
      end
   end

   assign bus.tick_o     = tick;
   assign bus.level_o    = level_q;
   assign bus.sel_tick_o = (state_q == ST_RUN) && tick[level_q];
   assign bus.pend_o     = (pend_q != level_q);
   assign bus.max_o      = (level_q == LVL_MAX);
   assign bus.state_o    = state_q;
endmodule

// File: tb/tb_genius_speed_ctrl.sv
// Bench for genius_speed_ctrl: vector table, directed corner sequences and a random run vs a cycle model.
module tb_genius_speed_ctrl;
   localparam int D0 = 8, D1 = 6, D2 = 4, D3 = 2, RPL = 2;

   logic clk, rst;
   int   total = 0, bad = 0;

   genius_speed_ctrl_if bus ();

   genius_speed_ctrl #(
      .DIV0(D0), .DIV1(D1), .DIV2(D2), .DIV3(D3), .ROUNDS_PER_LEVEL(RPL)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: since all dividers clear together, one "cycles since clear" count gives every tick.
   int divs [4] = '{D0, D1, D2, D3};
   int m_state, m_level, m_pend, m_rnd, m_since;

   function automatic int m_tick(int k);
      return ((m_since % divs[k]) == divs[k] - 1) ? 1 : 0;
   endfunction

   function automatic int m_outs();
      int t = 0;
      for (int k = 0; k < 4; k++) t |= m_tick(k) << k;
      return (t << 7) | (m_level << 5) | (((m_state == 1) ? m_tick(m_level) : 0) << 4) |
             (((m_pend != m_level) ? 1 : 0) << 3) | (((m_level == 3) ? 1 : 0) << 2) | m_state;
   endfunction

   function automatic int dut_outs();
      return (int'(bus.tick_o) << 7) | (int'(bus.level_o) << 5) | (int'(bus.sel_tick_o) << 4) |
             (int'(bus.pend_o) << 3) | (int'(bus.max_o) << 2) | int'(bus.state_o);
   endfunction

   task automatic m_step(input bit s, input bit r, input bit g, input bit rs);
      bit app;
      int old_pend;
      if (rs) begin
         m_state = 0; m_level = 0; m_pend = 0; m_rnd = 0; m_since = 0;
      end else begin
         app = (m_state == 1) && (m_tick(m_level) == 1) && (m_pend != m_level);
         old_pend = m_pend;
         if (s) begin
            m_state = 1; m_level = 0; m_pend = 0; m_rnd = 0; m_since = 0;
         end else begin
            if (m_state == 1 && g) m_state = 2;
            else if (m_state == 1 && r) begin
               m_rnd++;
               if (m_rnd == RPL) begin
                  m_rnd = 0;
                  if (m_pend < 3) m_pend++;
               end
            end
            if (app) begin
               m_level = old_pend; m_since = 0;
            end else m_since++;
         end
      end
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         if (bad <= 30) $display("FAIL %s got=0x%0h want=0x%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Called at a negedge: drive, let one posedge happen, come back to the next negedge and compare.
   task automatic cyc(input bit s, input bit r, input bit g, input bit rs = 1'b0);
      bus.start_i = s; bus.round_ok_i = r; bus.game_over_i = g; rst = rs;
      m_step(s, r, g, rs);
      @(negedge clk);
      bus.start_i = 1'b0; bus.round_ok_i = 1'b0; bus.game_over_i = 1'b0; rst = 1'b0;
      chk("model", dut_outs(), m_outs());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0);
   endtask

   task automatic cycles_to_tick0(input string nm, input int exp);
      int n = 0;
      do begin
         cyc(0, 0, 0);
         n++;
      end while (!bus.tick_o[0] && n < 60);
      chk(nm, n, exp);
   endtask

   typedef struct {
      bit s, r, g;
      int st, pend, lvl;
   } vec_t;
   vec_t tbl [12];

   initial begin
      int n;
      tbl[0]  = '{0, 1, 0, 0, 0, 0};
      tbl[1]  = '{0, 0, 1, 0, 0, 0};
      tbl[2]  = '{1, 0, 0, 1, 0, 0};
      tbl[3]  = '{0, 1, 0, 1, 0, 0};
      tbl[4]  = '{0, 1, 0, 1, 1, 0};
      tbl[5]  = '{0, 1, 1, 2, 1, 0};
      tbl[6]  = '{0, 1, 0, 2, 1, 0};
      tbl[7]  = '{0, 0, 0, 2, 1, 0};
      tbl[8]  = '{1, 0, 1, 1, 0, 0};
      tbl[9]  = '{0, 1, 0, 1, 0, 0};
      tbl[10] = '{0, 1, 1, 2, 0, 0};
      tbl[11] = '{0, 1, 0, 2, 0, 0};

      bus.start_i = 0; bus.round_ok_i = 0; bus.game_over_i = 0; rst = 1;
      m_step(0, 0, 0, 1);
      @(negedge clk);
      cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
      chk("reset_outs", dut_outs(), 0);

      // Reset and dividers
      n = 0;
      do begin
         cyc(0, 0, 0); n++;
      end while (!bus.tick_o[3] && n < 60);
      chk("tick3_first", n, 1);
      cycles_to_tick0("tick0_first", 6);
      cycles_to_tick0("tick0_period", 8);
      for (int i = 0; i < 32; i++) begin
         cyc(0, 0, 0);
         chk("idle_sel", int'(bus.sel_tick_o), 0);
      end

      // Vector table: events, ignore rules and priority
      for (int i = 0; i < 12; i++) begin
         cyc(tbl[i].s, tbl[i].r, tbl[i].g);
         chk($sformatf("tbl%0d_state", i), int'(bus.state_o), tbl[i].st);
         chk($sformatf("tbl%0d_pend", i), int'(bus.pend_o), tbl[i].pend);
         chk($sformatf("tbl%0d_level", i), int'(bus.level_o), tbl[i].lvl);
      end

      // Level-up, tick-aligned application, first full period at new level
      cyc(1, 0, 0); cyc(0, 1, 0);
      cyc(0, 1, 0);
      chk("lvlup_pend", int'(bus.pend_o), 1);
      n = 0;
      while (!bus.tick_o[0] && n < 60) begin
         cyc(0, 0, 0); n++;
      end
      chk("lvlup_lvl_before", int'(bus.level_o), 0);
      n = 0;
      do begin
         cyc(0, 0, 0); n++;
         if (n == 1) chk("lvlup_level", int'(bus.level_o), 1);
      end while (!bus.sel_tick_o && n < 60);
      chk("lvlup_sel_gap", n, 6);

      // Saturation
      cyc(1, 0, 0);
      for (int i = 0; i < 10; i++) begin
         cyc(0, 1, 0);
         idle($urandom_range(0, 9));
      end
      idle(40);
      chk("sat_level", int'(bus.level_o), 3);
      chk("sat_max", int'(bus.max_o), 1);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, 0);
         chk("sat_nopend", int'(bus.pend_o), 0);
      end

      // Freeze in OVER
      cyc(1, 0, 0); cyc(0, 1, 0); cyc(0, 1, 0);
      cyc(0, 0, 1);
      chk("frz_state", int'(bus.state_o), 2);
      for (int i = 0; i < 20; i++) begin
         cyc(0, 0, 0);
         chk("frz_level", int'(bus.level_o), 0);
      end
      chk("frz_pend", int'(bus.pend_o), 1);
      cyc(1, 0, 0);
      chk("frz_clear", int'(bus.pend_o), 0);

      // Random run against the model
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 31) == 0, $urandom_range(0, 199) == 0);

      // Reset mid-operation with a level pending at level 2
      cyc(1, 0, 0); cyc(0, 1, 0); cyc(0, 1, 0); idle(10);
      cyc(0, 1, 0); cyc(0, 1, 0); idle(10);
      cyc(0, 1, 0); cyc(0, 1, 0);
      chk("mid_level", int'(bus.level_o), 2);
      chk("mid_pend", int'(bus.pend_o), 1);
      cyc(0, 0, 0, 1);
      chk("mid_rst_outs", dut_outs(), 0);
      cycles_to_tick0("mid_tick0_first", 7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1);
   end
endmodule

// File: doc/genius_speed_ctrl.md
# genius_speed_ctrl

Speed scheduler for the Genius game's tempo path. Generates four divided tick enables (one per difficulty level) from the system clock and owns the 2-bit level select that picks among them. It counts successful rounds, raises difficulty every ROUNDS_PER_LEVEL rounds, and applies a new level only on a boundary of the currently selected tick, so no truncated or doubled periods reach the game FSM. It sits between the game controller (round/start/over events) and the sequence/LED timing logic (which consumes `sel_tick_o`).

## Interface
- `DIV0`, default 50_000_000: level-0 tick period in clocks (slowest).
- `DIV1`, default 37_500_000: level-1 tick period.
- `DIV2`, default 25_000_000: level-2 tick period.
- `DIV3`, default 12_500_000: level-3 tick period (fastest).
- `ROUNDS_PER_LEVEL`, default 4: successful rounds per level-up, must be >= 1.
- Legal configuration: DIV0 >= DIV1 >= DIV2 >= DIV3 >= 2.

Ports:
- `clk_i`  in  1  system clock; the block has one clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `start_i`  in  1  one-cycle pulse: start a new game.
- `round_ok_i`  in  1  one-cycle pulse: round completed correctly.
- `game_over_i`  in  1  one-cycle pulse: player failed.
- `tick_o`  out  4  `tick_o[k]` is the free-running level-k tick enable.
- `level_o`  out  2  applied level. Drives the tempo mux select.
- `sel_tick_o`  out  1  `tick_o[level_o]`, gated to RUN state only.
- `pend_o`  out  1  a level change is pending application.
- `max_o`  out  1  `level_o == 3`.
- `state_o`  out  2  FSM state: IDLE=0, RUN=1, OVER=2.

## Operation
- **Dividers.**
  - Counter k counts 0..DIVk-1 and wraps.
  - `tick_o[k]` = (cnt_k == DIVk-1), decoded from registers with no combinational input path.
  - All four counters run in every state.
  - All four counters clear to 0 on a level application and on an accepted `start_i`.
- **FSM.**
  - IDLE goes to RUN on `start_i`.
  - RUN goes to OVER on `game_over_i`.
  - OVER goes to RUN on `start_i`.
  - `start_i` in RUN restarts the game and stays in RUN.
- **On accepted start:**
  - `level_o` = 0 and `pend_lvl` = 0.
  - Round counter `rnd` = 0.
  - Dividers restart.
- **Round counting (RUN only).**
  - `round_ok_i` increments `rnd`.
  - If `rnd == ROUNDS_PER_LEVEL-1`: set `rnd` to 0 and set `pend_lvl` to min(`pend_lvl`+1, 3).
  - At `pend_lvl == 3`, `rnd` keeps wrapping and nothing else changes.
- **Level application.**
  - Occurs in any cycle where `tick_o[level_o]` = 1 and `pend_lvl != level_o`.
  - Next edge: `level_o` <= `pend_lvl` and all dividers clear.
  - Effect: the first period at the new level is a full DIV of the new level.
- `pend_o` = (`pend_lvl != level_o`).
- **Simultaneous-event priority:** `rst_i` > `start_i` > `game_over_i` > `round_ok_i`.
  - A lower-priority pulse in the same cycle is discarded, not queued.
- `round_ok_i` and `game_over_i` are ignored outside RUN.
- In OVER, `level_o` and `pend_lvl` freeze. There is no application, so a pending level stays pending until the next start clears it.

## Timing
- **Reset values:**
  - `state_o` = IDLE.
  - `level_o` = 0.
  - `pend_o` = 0.
  - `max_o` = 0.
  - `sel_tick_o` = 0.
  - `tick_o` = 4'b0000.
  - All counters = 0.
  - Reset mid-operation aborts any pending level.
- First `tick_o[k]` occurs DIVk-1 cycles after the first edge with `rst_i` low. Period thereafter is DIVk.
- `round_ok_i` pulse to `pend_o` high: 1 cycle, registered.
- Worst-case pending-to-applied latency: DIV(`level_o`) cycles.
- `level_o` changes exactly one cycle after the applying tick. The next `sel_tick_o` follows DIVnew-1 cycles later.
- All outputs are registered or decoded from registers only.

## Structure
- **Shared package `genius_pkg`:**
  - State enum (IDLE/RUN/OVER).
  - Level type `logic [1:0]` and constant `LVL_MAX = 2'd3`.
- **Sub-module `clk_div_tick`:**
  - Parameter DIV; ports `clk_i`, `rst_i`, `clr_i`, `tick_o`.
  - Counter width $clog2(DIV).
  - Instantiated 4 times.
- The top level holds the FSM, round counter, pending/apply logic, and the `sel_tick_o` select.

## Test plan
All scenarios use DIV0..3 = 8, 6, 4, 2 and ROUNDS_PER_LEVEL = 2.

1. **Reset and dividers.** Release reset, then idle for 48 cycles.
   - `tick_o[0]` first fires at cycle 7 with period 8; `tick_o[3]` first fires at cycle 1 with period 2.
   - `sel_tick_o` stays 0 and `level_o` stays 0.
2. **Level-up.** Issue `start_i`, then 2× `round_ok_i`.
   - `pend_o` = 1 one cycle after the second pulse.
   - `level_o` = 1 one cycle after the next `tick_o[0]`.
   - The next `sel_tick_o` occurs exactly 6 cycles after that `tick_o[0]`.
3. **Saturation.** Issue 10× `round_ok_i`, with ticks allowed between pulses.
   - `level_o` reaches 3 and `max_o` = 1.
   - Further pulses never set `pend_o`.
4. **Simultaneous events.** Assert `game_over_i` and `round_ok_i` in the same cycle.
   - State goes to OVER and `rnd` is unchanged.
   - Then assert `start_i` and `game_over_i` together: state is RUN with `level_o` = 0.
5. **Freeze in OVER.** Create a pending level, then issue `game_over_i` before the tick.
   - `level_o` never changes during OVER.
   - `start_i` clears `pend_o` to 0.
6. **Reset mid-operation.** Assert `rst_i` while `pend_o` = 1 at level 2.
   - All outputs return to reset values on the next edge.
   - `tick_o[0]` again first fires 7 cycles after release.
